pcie_line_pingpong: RTL

- Parametrised two-bank (ping-pong) line buffer between a video line source and the PCIe DMA read side, all in one clock domain.
- Writer FSM captures one line of runtime-programmable length into the free bank while the DMA reads the other, completed bank.
- Adds early-abort, per-bank committed length, bank handover handshake and dropped-line accounting.

---
 rtl/pcie_pkg.sv | 15 +
 rtl/pcie_sdp_ram.sv | 37 +++
 rtl/pcie_line_pingpong.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pcie_pkg.sv
// Shared types and default sizing for the PCIe line ping-pong buffer.
package pcie_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 12;
    localparam int unsigned DEF_MAX_LEN = 1920;
    localparam int unsigned DEF_LEN_W   = 16;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_FILL   = 2'd1,
        WR_COMMIT = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pcie_sdp_ram.sv
// Single-clock simple dual-port RAM with registered, enabled read port.
module pcie_sdp_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value while re_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pcie_line_pingpong.sv
// Two-bank line buffer: writer FSM fills the free bank while the DMA side
// reads the committed one. Bank select is the RAM address MSB.
module pcie_line_pingpong
    import pcie_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [LEN_W-1:0]  cfg_line_len,
    input  logic              line_start,
    input  logic              line_abort,
    output logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              bank_ready,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic [LEN_W-1:0]  drop_cnt
);

    wr_state_e        state_q, state_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [LEN_W-1:0] len_store_q [2];
    logic [LEN_W-1:0] len_store_d [2];
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [LEN_W-1:0] drop_q, drop_d;
    logic [LEN_W-1:0] len_clamp;
    logic             ram_we;

    assign len_clamp = (cfg_line_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_line_len;

    // Writer FSM next state plus reader bank release.
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        len_store_d = len_store_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;
        ram_we      = 1'b0;

        unique case (state_q)
            WR_IDLE: begin
                if (line_start) begin
                    if (full_q[wr_bank_q]) begin
                        if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                    end else if (len_clamp != '0) begin
                        len_d   = len_clamp;
                        wcnt_d  = '0;
                        state_d = WR_FILL;
                    end
                end
            end
            WR_FILL: begin
                if (line_abort) begin
                    state_d = WR_COMMIT;
                end else begin
                    wr_en  = 1'b1;
                    ram_we = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == len_q - 1'b1) begin
                        state_d = WR_COMMIT;
                    end
                end
            end
            WR_COMMIT: begin
                // An abort on the very first word leaves nothing to hand over.
                if (wcnt_q != '0) begin
                    full_d[wr_bank_q]      = 1'b1;
                    len_store_d[wr_bank_q] = wcnt_q;
                    wr_bank_d              = ~wr_bank_q;
                end
                state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase

        // Commit and release never hit the same bank, so both may apply.
        if (rd_done && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= WR_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            len_store_q <= '{default: '0};
            len_q       <= '0;
            wcnt_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            len_store_q <= len_store_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            drop_q      <= drop_d;
        end
    end

    assign busy       = (state_q != WR_IDLE);
    assign bank_ready = full_q[rd_bank_q];
    assign rd_len     = bank_ready ? len_store_q[rd_bank_q] : '0;
    assign drop_cnt   = drop_q;

    pcie_sdp_ram #(
        .DATA_W (DATA_W),
        .AW     (ADDR_W + 1)
    ) u_ram (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .we_i    (ram_we),
        .waddr_i ({wr_bank_q, wcnt_q[ADDR_W-1:0]}),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i ({rd_bank_q, rd_addr}),
        .rdata_o (rd_data)
    );

endmodule
